// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: instruction-decode front end for the immediate-extension unit.
// Classifies the opcode into an extOp code, slices the five raw immediate
// fields, flags illegal opcodes and presents the result through a one-stage
// output register (main) backed by a one-entry skid register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer may change its offer freely while ready is low. Once
// out_valid is high, the payload stays stable until out_valid && out_ready.
// Both ready and valid outputs come straight from registered state.
module id_imm_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [2:0]       extOp,
    output logic [11:0]      immTypeI,
    output logic [11:0]      immTypeS,
    output logic [12:0]      immTypeB,
    output logic [19:0]      immTypeU,
    output logic [19:0]      immTypeJ,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [1:0]       dbg_state
);

    // Opcode values recognised by the decoder.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // extOp codes understood by the extension unit.
    localparam logic [2:0] EXT_NONE = 3'd0;
    localparam logic [2:0] EXT_I    = 3'd1;
    localparam logic [2:0] EXT_S    = 3'd2;
    localparam logic [2:0] EXT_B    = 3'd3;
    localparam logic [2:0] EXT_U    = 3'd4;
    localparam logic [2:0] EXT_J    = 3'd5;

    // Occupancy: EMPTY = nothing held, HOLD = main only, FULL = main + skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  ext_op;
        logic [11:0] imm_i;
        logic [11:0] imm_s;
        logic [12:0] imm_b;
        logic [19:0] imm_u;
        logic [19:0] imm_j;
        logic        illegal;
    } payload_t;

    state_t           state_q, state_d;
    payload_t         main_q, main_d;
    payload_t         skid_q, skid_d;
    payload_t         dec;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             accept;
    logic             drain;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign dbg_state = state_q;

    // Combinational decode of the offered instruction; fields are always sliced.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.imm_i   = in_instr[31:20];
        dec.imm_s   = {in_instr[31:25], in_instr[11:7]};
        dec.imm_b   = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        dec.imm_u   = in_instr[31:12];
        dec.imm_j   = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
        dec.ext_op  = EXT_NONE;
        dec.illegal = 1'b0;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: dec.ext_op = EXT_I;
            OP_STORE:                 dec.ext_op = EXT_S;
            OP_BRANCH:                dec.ext_op = EXT_B;
            OP_LUI, OP_AUIPC:         dec.ext_op = EXT_U;
            OP_JAL:                   dec.ext_op = EXT_J;
            OP_REG, OP_SYSTEM:        dec.ext_op = EXT_NONE;
            default:                  dec.illegal = 1'b1;
        endcase
    end

    // Next occupancy state and main/skid payload routing; flush empties both.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = dec;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (drain && accept) begin
                    main_d = dec;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no accept can coincide with the drain.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Saturating count of illegal instructions handed downstream.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (drain && main_q.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    // State, payload and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_pc      = main_q.pc;
    assign extOp       = main_q.ext_op;
    assign immTypeI    = main_q.imm_i;
    assign immTypeS    = main_q.imm_s;
    assign immTypeB    = main_q.imm_b;
    assign immTypeU    = main_q.imm_u;
    assign immTypeJ    = main_q.imm_j;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Bench for id_imm_ctrl: directed scenarios plus a randomized stream, with a
// negedge monitor that scoreboards every delivered instruction.
module tb_id_imm_ctrl;

    localparam int CNT_W = 8;
    localparam int EW    = 113;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [2:0]       extOp;
    logic [11:0]      immTypeI;
    logic [11:0]      immTypeS;
    logic [12:0]      immTypeB;
    logic [19:0]      immTypeU;
    logic [19:0]      immTypeJ;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;
    logic [1:0]       dbg_state;

    logic [EW-1:0] exp_q[$];
    int            vec_cnt  = 0;
    int            miss_cnt = 0;

    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] prev_got;
    logic          prev_stall = 1'b0;

    logic [6:0] opc_tab[12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h33, 7'h73, 7'h00, 7'h7F};

    id_imm_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .extOp(extOp), .immTypeI(immTypeI),
        .immTypeS(immTypeS), .immTypeB(immTypeB), .immTypeU(immTypeU),
        .immTypeJ(immTypeJ), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference decode of one instruction into the flattened output vector.
    function automatic logic [EW-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
        logic [6:0] op;
        logic [2:0] e;
        logic       ill;
        op  = ins[6:0];
        e   = 3'd0;
        ill = 1'b0;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67)      e = 3'd1;
        else if (op == 7'h23)                               e = 3'd2;
        else if (op == 7'h63)                               e = 3'd3;
        else if (op == 7'h37 || op == 7'h17)                e = 3'd4;
        else if (op == 7'h6F)                               e = 3'd5;
        else if (op == 7'h33 || op == 7'h73)                e = 3'd0;
        else                                                ill = 1'b1;
        return {pc, e, ins[31:20], ins[31:25], ins[11:7],
                ins[31], ins[7], ins[30:25], ins[11:8], 1'b0,
                ins[31:12], ins[31], ins[19:12], ins[20], ins[30:21], ill};
    endfunction

    // Scoreboard monitor: pop/compare on delivery, push on accept, hold check on stall.
    always @(negedge clk) begin
        if (!reset) begin
            mon_got = {out_pc, extOp, immTypeI, immTypeS, immTypeB, immTypeU, immTypeJ, out_illegal};
            if (prev_stall) begin
                vec_cnt++;
                if (mon_got !== prev_got) begin
                    miss_cnt++;
                    $display("FAIL stall_hold got=%h required=%h", mon_got, prev_got);
                end
            end
            if (out_valid && out_ready) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL deliver_unexpected got=%h required=nothing", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        miss_cnt++;
                        $display("FAIL deliver got=%h required=%h", mon_got, mon_exp);
                    end
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
            prev_stall = out_valid && !out_ready && !flush;
            prev_got   = mon_got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic test_reset();
        logic [EW-1:0] got;
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        got = {out_pc, extOp, immTypeI, immTypeS, immTypeB, immTypeU, immTypeJ, out_illegal};
        vec_cnt++; if (got !== '0) begin miss_cnt++; $display("FAIL reset_payload got=%h required=0", got); end
        vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        vec_cnt++; if (illegal_cnt !== '0) begin miss_cnt++; $display("FAIL reset_cnt got=%0d required=0", illegal_cnt); end
        vec_cnt++; if (dbg_state !== 2'd0) begin miss_cnt++; $display("FAIL reset_state got=%0d required=0", dbg_state); end
    endtask

    task automatic test_decode();
        logic [31:0] ins[5];
        logic [2:0]  ext[5];
        logic [19:0] fld[5];
        logic [19:0] obs;
        ins = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h008000EF, 32'h123450B7};
        ext = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
        fld = '{20'hFFF, 20'h008, 20'h1FFC, 20'h00004, 20'h12345};
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc = 32'h1000 + 32'(4 * i);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            case (i)
                0:       obs = {8'd0, immTypeI};
                1:       obs = {8'd0, immTypeS};
                2:       obs = {7'd0, immTypeB};
                3:       obs = immTypeJ;
                default: obs = immTypeU;
            endcase
            vec_cnt++; if (out_valid !== 1'b1) begin miss_cnt++; $display("FAIL decode%0d_latency got=%b required=1", i, out_valid); end
            vec_cnt++; if (extOp !== ext[i]) begin miss_cnt++; $display("FAIL decode%0d_extop got=%0d required=%0d", i, extOp, ext[i]); end
            vec_cnt++; if (obs !== fld[i]) begin miss_cnt++; $display("FAIL decode%0d_field got=%h required=%h", i, obs, fld[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] ins[4];
        logic [31:0] r;
        logic        rdy;
        int          k;
        int          budget;
        for (int j = 0; j < 4; j++) begin
            r = $urandom();
            ins[j] = {r[31:7], 7'h13};
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_instr = ins[k]; in_pc = 32'h2000 + 32'(4 * k);
            @(negedge clk);
            rdy = in_ready;
            if (c >= 2) begin
                vec_cnt++; if (rdy !== 1'b0) begin miss_cnt++; $display("FAIL bp_in_ready_c%0d got=%b required=0", c, rdy); end
            end
            @(posedge clk); #1;
            if (rdy) k++;
        end
        vec_cnt++; if (k !== 2) begin miss_cnt++; $display("FAIL bp_accepted got=%0d required=2", k); end
        vec_cnt++; if (dbg_state !== 2'd2) begin miss_cnt++; $display("FAIL bp_state got=%0d required=2", dbg_state); end
        out_ready = 1'b1;
        budget = 0;
        while (k < 4 && budget < 20) begin
            in_valid = 1'b1; in_instr = ins[k]; in_pc = 32'h2000 + 32'(4 * k);
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) k++;
            budget++;
        end
        in_valid = 1'b0;
        vec_cnt++; if (k !== 4) begin miss_cnt++; $display("FAIL bp_all_accepted got=%0d required=4", k); end
        repeat (4) @(posedge clk);
        #1;
        vec_cnt++; if (exp_q.size() !== 0) begin miss_cnt++; $display("FAIL bp_outstanding got=%0d required=0", exp_q.size()); end
        vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL bp_idle got=%b required=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h4000;
        @(posedge clk); #1;
        in_instr = 32'h00200113; in_pc = 32'h4004;
        @(posedge clk); #1;
        flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'hDEAD0000;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL flush_out_valid got=%b required=0", out_valid); end
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL flush_in_ready got=%b required=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL flush_leak%0d got=%b required=0", i, out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = $urandom();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vec_cnt++; if (out_illegal !== 1'b1) begin miss_cnt++; $display("FAIL ill_flag got=%b required=1", out_illegal); end
        vec_cnt++; if (extOp !== 3'd0) begin miss_cnt++; $display("FAIL ill_extop got=%0d required=0", extOp); end
        @(posedge clk); #1;
        @(negedge clk);
        vec_cnt++; if (illegal_cnt !== 8'd1) begin miss_cnt++; $display("FAIL ill_cnt1 got=%0d required=1", illegal_cnt); end
        in_valid = 1'b1;
        for (int i = 0; i < 299; i++) begin
            in_pc = $urandom();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (illegal_cnt !== 8'd255) begin miss_cnt++; $display("FAIL ill_saturate got=%0d required=255", illegal_cnt); end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] got;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = 32'h00A00513; in_pc = 32'h3000 + 32'(4 * i);
            @(posedge clk); #1;
        end
        #2 reset = 1'b1; in_valid = 1'b0;
        #1;
        exp_q.delete();
        got = {out_pc, extOp, immTypeI, immTypeS, immTypeB, immTypeU, immTypeJ, out_illegal};
        vec_cnt++; if (got !== '0) begin miss_cnt++; $display("FAIL areset_payload got=%h required=0", got); end
        vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL areset_out_valid got=%b required=0", out_valid); end
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL areset_in_ready got=%b required=1", in_ready); end
        vec_cnt++; if (illegal_cnt !== '0) begin miss_cnt++; $display("FAIL areset_cnt got=%0d required=0", illegal_cnt); end
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL post_reset_valid got=%b required=0", out_valid); end
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL post_reset_ready got=%b required=1", in_ready); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        int          budget;
        for (int c = 0; c < 400; c++) begin
            r = $urandom();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = {r[31:7], opc_tab[$urandom_range(0, 11)]};
            in_pc     = $urandom();
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        @(negedge clk);
        vec_cnt++; if (exp_q.size() !== 0) begin miss_cnt++; $display("FAIL rand_drain got=%0d required=0", exp_q.size()); end
        vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL rand_idle got=%b required=0", out_valid); end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Test sequence and summary.
    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
